// File: rtl/clk_period_meter_if.sv
// Result bundle for clk_period_meter: sampled divided clock in, measurements out.
// master = meter side, slave = status/debug consumer that also sources sig_in.
interface clk_period_meter_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             locked;
  logic             timeout;
  logic             duty_err;

  modport master (
    input  sig_in,
    output period_out, high_out, meas_valid,
    output locked, timeout, duty_err
  );

  modport slave (
    output sig_in,
    input  period_out, high_out, meas_valid,
    input  locked, timeout, duty_err
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period/high time of a slow async clock; flags lock and timeout.
// Optional duty-cycle check enabled by defining DUTY_CHECK_EN.
module clk_period_meter #(
  parameter int CNT_W      = 28,
  parameter int EXPECTED   = 85106,
  parameter int TOL        = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 170212
) (
  input  logic clock_in,
  input  logic reset_n,
  clk_period_meter_if.master meter
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0] EXP_X = (CNT_W+1)'(EXPECTED);
  localparam logic [CNT_W:0] TOL_X = (CNT_W+1)'(TOL);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

  typedef enum logic {
    ACQUIRE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             prev;
  logic             rise;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nx;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   dev;
  logic             in_tol;
  logic             good;

  always_comb begin
    rise    = s2 & ~prev;
    tmo_hit = (cnt == TMO) & ~rise;
    cnt_x   = {1'b0, cnt};
    dev     = (cnt_x >= EXP_X) ? cnt_x - EXP_X
                               : EXP_X - cnt_x;
    in_tol  = dev <= TOL_X;
  end

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W+1:0] DTOL = (CNT_W+2)'(2 * TOL);

  logic [CNT_W+1:0] h2;
  logic [CNT_W+1:0] c2;
  logic [CNT_W+1:0] ddev;
  logic             duty_bad;

  always_comb begin
    h2       = {1'b0, hcnt, 1'b0};
    c2       = {2'b00, cnt};
    ddev     = (h2 >= c2) ? h2 - c2 : c2 - h2;
    duty_bad = ddev > DTOL;
    good     = in_tol & ~duty_bad;
  end
`else
  assign good = in_tol;
  assign meter.duty_err = 1'b0;
`endif

  always_comb begin
    run_nx = '0;
    if (good)
      run_nx = (run == RUN_MAX) ? run
                                : run + RUN_W'(1);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ACQUIRE;
      s1               <= 1'b0;
      s2               <= 1'b0;
      prev             <= 1'b0;
      cnt              <= '0;
      hcnt             <= '0;
      run              <= '0;
      meter.period_out <= '0;
      meter.high_out   <= '0;
      meter.meas_valid <= 1'b0;
      meter.locked     <= 1'b0;
      meter.timeout    <= 1'b0;
`ifdef DUTY_CHECK_EN
      meter.duty_err   <= 1'b0;
`endif
    end else begin
      s1   <= meter.sig_in;
      s2   <= s1;
      prev <= s2;
      meter.meas_valid <= 1'b0;

      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);

      if (rise)
        hcnt <= CNT_W'(1);
      else if (s2 && hcnt != CNT_MAX)
        hcnt <= hcnt + CNT_W'(1);

      // the first rise after acquire only opens a period
      unique case (1'b1)
        rise: begin
          if (state == ACQUIRE) begin
            state <= MEASURE;
          end else begin
            meter.period_out <= cnt;
            meter.high_out   <= hcnt;
            meter.meas_valid <= 1'b1;
            meter.timeout    <= 1'b0;
            run              <= run_nx;
            meter.locked     <= run_nx == RUN_MAX;
`ifdef DUTY_CHECK_EN
            meter.duty_err   <= duty_bad;
`endif
          end
        end
        tmo_hit: begin
          meter.timeout <= 1'b1;
          meter.locked  <= 1'b0;
          run           <= '0;
          state         <= ACQUIRE;
        end
        default: ;
      endcase
    end
  end

endmodule
